segment_extractor_onesz: RTL and testbench
==========================================

// Module: segment_extractor_onesz
// PURPOSE
// - Upstream neighbour of the one-size segment remover on the NMU ingress path.
// - Passes an AXI stream through unchanged with one register stage.
// - Captures the fixed-size byte segment at EXTRACT_OFFSET (e.g. the VLAN tag at bytes 12..15) and
//   emits it once per packet on a sideband valid/ready channel, before the remover strips it.
// PARAMETERS
// AXIS_BUS_WIDTH      64    data width in bits; multiple of 16
// AXIS_TUSER_WIDTH    4     tuser width, passed through
// MAX_PACKET_LENGTH   1522  byte-counter saturation value; counter width $clog2(MAX_PACKET_LENGTH+1)
// EXTRACT_OFFSET      12    byte offset of segment from packet start; even
// EXTRACT_SIZE_BYTES  4     segment size in bytes; even, >0
// PORTS
// aclk             in   1                       clock
// areset           in   1                       reset, synchronous, active-high
// axis_in_tdata    in   AXIS_BUS_WIDTH          input data, byte 0 = bits [7:0]
// axis_in_tkeep    in   AXIS_BUS_WIDTH/8        input byte enables
// axis_in_tuser    in   AXIS_TUSER_WIDTH        input user sideband
// axis_in_tlast    in   1                       input end of packet
// axis_in_tvalid   in   1                       input valid
// axis_in_tready   out  1                       input ready
// axis_out_tdata   out  AXIS_BUS_WIDTH          output data
// axis_out_tkeep   out  AXIS_BUS_WIDTH/8        output byte enables
// axis_out_tuser   out  AXIS_TUSER_WIDTH        output user sideband
// axis_out_tlast   out  1                       output end of packet
// axis_out_tvalid  out  1                       output valid
// axis_out_tready  in   1                       output ready
// seg_out_tdata    out  EXTRACT_SIZE_BYTES*8    captured segment; packet byte EXTRACT_OFFSET in bits [7:0]
// seg_out_complete out  1                       1 = every segment byte was present in the packet
// seg_out_tvalid   out  1                       segment record valid, one per packet
// seg_out_tready   in   1                       segment record accepted
// BEHAVIOUR
// - Reset: all output valids 0; output data, tkeep, tuser, tlast 0; capture register 0;
//   byte counter 0; FSM in S_CAPTURE. A mid-packet reset discards the partial packet and any pending
//   segment record. The first beat accepted after reset is treated as byte 0 of a new packet.
// - Data path:
//   - One full register slice with latency 1.
//   - slice_ready = !axis_out_tvalid | axis_out_tready.
//   - Data, tkeep, tuser and tlast are copied bit-exact.
// - axis_in_tready = slice_ready & (!axis_in_tlast | !seg_out_tvalid | seg_out_tready).
//   - Only the tlast beat stalls on an unconsumed segment record.
// - Byte counter bcnt holds the packet offset of the current beat's byte 0.
//   - Advances by AXIS_BUS_WIDTH/8 on each accepted non-last beat.
//   - Saturates at MAX_PACKET_LENGTH.
//   - Clears on an accepted tlast beat.
// - Non-last beats are full. The tkeep of the last beat is contiguous from bit 0.
// - FSM, evaluated on accepted beats only:
//   - S_CAPTURE: for each byte i with tkeep[i]=1 and EXTRACT_OFFSET <= bcnt+i < EXTRACT_OFFSET+EXTRACT_SIZE_BYTES,
//     write the byte to cap[bcnt+i-EXTRACT_OFFSET] and set got[that index].
//     - Go to S_PASS when bcnt+AXIS_BUS_WIDTH/8 >= EXTRACT_OFFSET+EXTRACT_SIZE_BYTES and the beat is not last.
//   - S_PASS: no capture.
//   - Any state, accepted tlast beat:
//     - Load seg_out_tdata = cap (including any bytes captured on this beat).
//     - Load seg_out_complete = &got.
//     - Set seg_out_tvalid.
//     - Clear cap and got.
//     - Go to S_CAPTURE.
//     - This happens in the same cycle as the slice load, so seg_out_tvalid rises together with
//       axis_out_tvalid for the tlast beat.
// - Segment channel: seg_out_tvalid clears on seg_out_tvalid & seg_out_tready unless it is reloaded
//   in the same cycle. A simultaneous handshake and load presents the new record next cycle.
// - Short packet: missing bytes read 0 and seg_out_complete = 0.
// TESTING
// All tests use defaults: 64-bit bus, offset 12, size 4.
// 1. Send 64B packet, beat1 = 0x0400_0081_0706_0504 ready-high.
//    Expect seg_out_tdata = 0x0400_0081, complete = 1, and the output stream identical to the input,
//    delayed 1 cycle.
// 2. Send 14B packet, beat1 tkeep = 0x3F, bytes 12,13 = 0x81,0x00.
//    Expect seg_out_tdata = 0x0000_0081, complete = 0.
// 3. Send single-beat 8B packet.
//    Expect seg_out_tdata = 0, complete = 0, one record.
// 4. Send two back-to-back 64B packets with seg_out_tready = 0.
//    Expect the second tlast beat to be held (axis_in_tready = 0) and the first record stable.
//    Raise seg_out_tready and expect both records to arrive in order.
// 5. Drive random axis_out_tready (50%) over 100 packets of 14..1522B.
//    Expect the output stream to equal the input and one record per packet, matching the model.
// 6. Assert areset during beat 1 of a packet, then send a new 64B packet.
//    Expect no record for the aborted packet and a correct record for the new one.

Source files
------------

// File: rtl/segment_extractor_onesz.sv
// AXI-stream pass-through with one register slice that captures a fixed-size byte segment
// at a fixed packet offset and emits it once per packet on a valid/ready sideband.
module segment_extractor_onesz #(
  parameter int unsigned AXIS_BUS_WIDTH     = 64,
  parameter int unsigned AXIS_TUSER_WIDTH   = 4,
  parameter int unsigned MAX_PACKET_LENGTH  = 1522,
  parameter int unsigned EXTRACT_OFFSET     = 12,
  parameter int unsigned EXTRACT_SIZE_BYTES = 4
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [AXIS_BUS_WIDTH-1:0]       axis_in_tdata,
  input  logic [AXIS_BUS_WIDTH/8-1:0]     axis_in_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]     axis_in_tuser,
  input  logic                            axis_in_tlast,
  input  logic                            axis_in_tvalid,
  output logic                            axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]       axis_out_tdata,
  output logic [AXIS_BUS_WIDTH/8-1:0]     axis_out_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]     axis_out_tuser,
  output logic                            axis_out_tlast,
  output logic                            axis_out_tvalid,
  input  logic                            axis_out_tready,
  output logic [EXTRACT_SIZE_BYTES*8-1:0] seg_out_tdata,
  output logic                            seg_out_complete,
  output logic                            seg_out_tvalid,
  input  logic                            seg_out_tready
);

  localparam int unsigned KeepW = AXIS_BUS_WIDTH / 8;
  localparam int unsigned CntW  = $clog2(MAX_PACKET_LENGTH + 1);
  localparam int unsigned SegW  = EXTRACT_SIZE_BYTES * 8;

  typedef enum logic [0:0] {StCapture, StPass} state_e;

  state_e                        state_q;
  logic [CntW-1:0]               bcnt_q;
  logic [SegW-1:0]               cap_q, cap_d;
  logic [EXTRACT_SIZE_BYTES-1:0] got_q, got_d;
  logic [AXIS_BUS_WIDTH-1:0]     out_tdata_q;
  logic [KeepW-1:0]              out_tkeep_q;
  logic [AXIS_TUSER_WIDTH-1:0]   out_tuser_q;
  logic                          out_tlast_q, out_tvalid_q;
  logic [SegW-1:0]               seg_tdata_q;
  logic                          seg_complete_q, seg_tvalid_q;

  logic            slice_ready, in_ready, accept, capture_done;
  logic [31:0]     bcnt_ext, bcnt_inc;
  logic [CntW-1:0] bcnt_sat;

  assign slice_ready = !out_tvalid_q | axis_out_tready;
  // Only the tlast beat must wait for the previous segment record to drain.
  assign in_ready    = slice_ready & (!axis_in_tlast | !seg_tvalid_q | seg_out_tready);
  assign accept      = axis_in_tvalid & in_ready;

  assign bcnt_ext     = {{(32 - CntW){1'b0}}, bcnt_q};
  assign bcnt_inc     = bcnt_ext + KeepW;
  assign bcnt_sat     = (bcnt_inc >= MAX_PACKET_LENGTH) ? CntW'(MAX_PACKET_LENGTH)
                                                         : bcnt_inc[CntW-1:0];
  assign capture_done = bcnt_inc >= (EXTRACT_OFFSET + EXTRACT_SIZE_BYTES);

  always_comb begin
    cap_d = cap_q;
    got_d = got_q;
    if (state_q == StCapture) begin
      for (int unsigned i = 0; i < KeepW; i++) begin
        for (int unsigned j = 0; j < EXTRACT_SIZE_BYTES; j++) begin
          if (axis_in_tkeep[i] && (bcnt_ext + i == EXTRACT_OFFSET + j)) begin
            cap_d[j*8 +: 8] = axis_in_tdata[i*8 +: 8];
            got_d[j]        = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q        <= StCapture;
      bcnt_q         <= '0;
      cap_q          <= '0;
      got_q          <= '0;
      out_tdata_q    <= '0;
      out_tkeep_q    <= '0;
      out_tuser_q    <= '0;
      out_tlast_q    <= 1'b0;
      out_tvalid_q   <= 1'b0;
      seg_tdata_q    <= '0;
      seg_complete_q <= 1'b0;
      seg_tvalid_q   <= 1'b0;
    end else begin
      if (slice_ready) out_tvalid_q <= accept;
      if (seg_out_tready) seg_tvalid_q <= 1'b0;
      if (accept) begin
        out_tdata_q <= axis_in_tdata;
        out_tkeep_q <= axis_in_tkeep;
        out_tuser_q <= axis_in_tuser;
        out_tlast_q <= axis_in_tlast;
        if (axis_in_tlast) begin
          bcnt_q         <= '0;
          seg_tdata_q    <= cap_d;
          seg_complete_q <= &got_d;
          seg_tvalid_q   <= 1'b1;
          cap_q          <= '0;
          got_q          <= '0;
          state_q        <= StCapture;
        end else begin
          bcnt_q <= bcnt_sat;
          if (state_q == StCapture) begin
            cap_q <= cap_d;
            got_q <= got_d;
            if (capture_done) state_q <= StPass;
          end
        end
      end
    end
  end

  assign axis_in_tready   = in_ready;
  assign axis_out_tdata   = out_tdata_q;
  assign axis_out_tkeep   = out_tkeep_q;
  assign axis_out_tuser   = out_tuser_q;
  assign axis_out_tlast   = out_tlast_q;
  assign axis_out_tvalid  = out_tvalid_q;
  assign seg_out_tdata    = seg_tdata_q;
  assign seg_out_complete = seg_complete_q;
  assign seg_out_tvalid   = seg_tvalid_q;

endmodule

// File: tb/tb_segment_extractor_onesz.sv
// Directed bench for segment_extractor_onesz: stream pass-through, segment capture, short
// packets, record back-pressure, random output stalls and mid-packet reset.
module tb_segment_extractor_onesz;

  logic        aclk = 1'b0;
  logic        areset;
  logic [63:0] axis_in_tdata;
  logic [7:0]  axis_in_tkeep;
  logic [3:0]  axis_in_tuser;
  logic        axis_in_tlast, axis_in_tvalid, axis_in_tready;
  logic [63:0] axis_out_tdata;
  logic [7:0]  axis_out_tkeep;
  logic [3:0]  axis_out_tuser;
  logic        axis_out_tlast, axis_out_tvalid, axis_out_tready;
  logic [31:0] seg_out_tdata;
  logic        seg_out_complete, seg_out_tvalid, seg_out_tready;

  segment_extractor_onesz dut (
    .aclk             (aclk),
    .areset           (areset),
    .axis_in_tdata    (axis_in_tdata),
    .axis_in_tkeep    (axis_in_tkeep),
    .axis_in_tuser    (axis_in_tuser),
    .axis_in_tlast    (axis_in_tlast),
    .axis_in_tvalid   (axis_in_tvalid),
    .axis_in_tready   (axis_in_tready),
    .axis_out_tdata   (axis_out_tdata),
    .axis_out_tkeep   (axis_out_tkeep),
    .axis_out_tuser   (axis_out_tuser),
    .axis_out_tlast   (axis_out_tlast),
    .axis_out_tvalid  (axis_out_tvalid),
    .axis_out_tready  (axis_out_tready),
    .seg_out_tdata    (seg_out_tdata),
    .seg_out_complete (seg_out_complete),
    .seg_out_tvalid   (seg_out_tvalid),
    .seg_out_tready   (seg_out_tready)
  );

  always #5 aclk = ~aclk;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          rand_rdy = 1'b0;
  logic [7:0]  pkt [0:2047];
  logic [79:0] exp_beats[$], got_beats[$];
  logic [32:0] exp_seg[$], got_seg[$];

  // Observe completed handshakes mid-cycle.
  always @(negedge aclk) begin
    if (!areset) begin
      if (axis_out_tvalid && axis_out_tready)
        got_beats.push_back({3'b0, axis_out_tuser, axis_out_tlast, axis_out_tkeep, axis_out_tdata});
      if (seg_out_tvalid && seg_out_tready)
        got_seg.push_back({seg_out_complete, seg_out_tdata});
    end
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
    if (rand_rdy) axis_out_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_hs();
    int   cyc = 0;
    logic hs;
    do begin
      @(negedge aclk);
      hs = axis_in_tready;
      tick();
      cyc++;
      if (!hs && cyc > 5000) begin
        n_fail++;
        $display("FAIL input handshake timeout observed=none required=accept");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
      end
    end while (!hs);
  endtask

  task automatic drive_beat(input int len, input int b);
    int         n;
    logic [8:0] m;
    n = len - 8 * b;
    if (n > 8) n = 8;
    m = (9'd1 << n) - 9'd1;
    for (int k = 0; k < 8; k++) axis_in_tdata[k*8 +: 8] = pkt[8*b + k];
    axis_in_tkeep  = m[7:0];
    axis_in_tuser  = 4'(b);
    axis_in_tlast  = (8 * (b + 1) >= len);
    axis_in_tvalid = 1'b1;
  endtask

  // chk: slice must hold the just-accepted beat (output always ready).
  task automatic send_pkt(input int len, input bit hold_last, input bit chk);
    logic [79:0] eb;
    logic [32:0] es;
    for (int b = 0; b < (len + 7) / 8; b++) begin
      drive_beat(len, b);
      eb = {3'b0, axis_in_tuser, axis_in_tlast, axis_in_tkeep, axis_in_tdata};
      exp_beats.push_back(eb);
      if (hold_last && axis_in_tlast) begin
        repeat (4) begin
          @(negedge aclk);
          check("t4_tlast_held", {79'b0, axis_in_tready}, 80'd0);
          check("t4_rec_stable", {47'b0, seg_out_tvalid, seg_out_complete, seg_out_tdata},
                {47'b0, 1'b1, exp_seg[0]});
          tick();
        end
        seg_out_tready = 1'b1;
      end
      wait_hs();
      if (chk) begin
        check("lat1_beat", {axis_out_tvalid, axis_out_tuser, axis_out_tlast, axis_out_tkeep,
              axis_out_tdata}, {1'b1, eb[76:0]});
        if (eb[72]) check("seg_with_tlast", {79'b0, seg_out_tvalid}, 80'd1);
      end
    end
    axis_in_tvalid = 1'b0;
    axis_in_tlast  = 1'b0;
    es = '0;
    for (int j = 0; j < 4; j++) if (12 + j < len) es[j*8 +: 8] = pkt[12 + j];
    es[32] = (len >= 16);
    exp_seg.push_back(es);
  endtask

  task automatic drain();
    int cyc = 0;
    while ((got_beats.size() != exp_beats.size() || got_seg.size() != exp_seg.size())
           && cyc < 4000) begin
      tick();
      cyc++;
    end
    repeat (3) tick();
  endtask

  task automatic compare(input string tag);
    check({tag, "_nbeats"}, 80'(got_beats.size()), 80'(exp_beats.size()));
    check({tag, "_nrecs"}, 80'(got_seg.size()), 80'(exp_seg.size()));
    while (got_beats.size() > 0 && exp_beats.size() > 0)
      check({tag, "_beat"}, got_beats.pop_front(), exp_beats.pop_front());
    while (got_seg.size() > 0 && exp_seg.size() > 0)
      check({tag, "_rec"}, {47'b0, got_seg.pop_front()}, {47'b0, exp_seg.pop_front()});
    got_beats.delete(); exp_beats.delete(); got_seg.delete(); exp_seg.delete();
  endtask

  initial begin
    int len;
    for (int k = 0; k < 2048; k++) pkt[k] = 8'h00;
    areset = 1'b1;
    axis_in_tdata = '0; axis_in_tkeep = '0; axis_in_tuser = '0;
    axis_in_tlast = 1'b0; axis_in_tvalid = 1'b0;
    axis_out_tready = 1'b1; seg_out_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    #1;
    check("rst_out_valid", {79'b0, axis_out_tvalid}, 80'd0);
    check("rst_out_data", {3'b0, axis_out_tuser, axis_out_tlast, axis_out_tkeep, axis_out_tdata},
          80'd0);
    check("rst_seg", {47'b0, seg_out_tvalid, seg_out_complete, seg_out_tdata}, 80'd0);
    check("rst_in_ready", {79'b0, axis_in_tready}, 80'd1);

    // 1: 64B packet, bytes 8..15 = 04 05 06 07 81 00 00 04
    for (int k = 0; k < 64; k++) pkt[k] = 8'(k + 8'h20);
    pkt[8] = 8'h04; pkt[9] = 8'h05; pkt[10] = 8'h06; pkt[11] = 8'h07;
    pkt[12] = 8'h81; pkt[13] = 8'h00; pkt[14] = 8'h00; pkt[15] = 8'h04;
    send_pkt(64, 1'b0, 1'b1);
    drain();
    check("t1_seg", {47'b0, got_seg[0]}, {47'b0, 1'b1, 32'h0400_0081});
    compare("t1");

    // 2: 14B packet, bytes 12,13 = 81 00
    for (int k = 0; k < 64; k++) pkt[k] = 8'(k + 8'h30);
    pkt[12] = 8'h81; pkt[13] = 8'h00;
    send_pkt(14, 1'b0, 1'b1);
    drain();
    check("t2_seg", {47'b0, got_seg[0]}, {47'b0, 1'b0, 32'h0000_0081});
    compare("t2");

    // 3: single-beat 8B packet
    for (int k = 0; k < 64; k++) pkt[k] = 8'(k + 8'hA0);
    send_pkt(8, 1'b0, 1'b1);
    drain();
    check("t3_seg", {47'b0, got_seg[0]}, {47'b0, 1'b0, 32'h0});
    compare("t3");

    // 4: back-to-back packets with the record channel stalled
    seg_out_tready = 1'b0;
    for (int k = 0; k < 64; k++) pkt[k] = 8'(k + 8'h10);
    send_pkt(64, 1'b0, 1'b0);
    for (int k = 0; k < 64; k++) pkt[k] = 8'(k + 8'h40);
    send_pkt(64, 1'b1, 1'b0);
    drain();
    check("t4_first", {47'b0, got_seg[0]}, {47'b0, 1'b1, 32'h1F1E_1D1C});
    compare("t4");

    // 5: random lengths and contents with random output back-pressure
    rand_rdy = 1'b1;
    for (int p = 0; p < 100; p++) begin
      len = $urandom_range(14, 1522);
      for (int k = 0; k < len + 8; k++) pkt[k] = 8'($urandom);
      send_pkt(len, 1'b0, 1'b0);
    end
    drain();
    compare("t5");
    rand_rdy = 1'b0;
    axis_out_tready = 1'b1;

    // 6: reset in the middle of a packet, then a fresh packet
    for (int k = 0; k < 64; k++) pkt[k] = 8'(k + 8'h55);
    drive_beat(64, 0);
    wait_hs();
    drive_beat(64, 1);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    axis_in_tvalid = 1'b0;
    axis_in_tlast  = 1'b0;
    got_beats.delete(); exp_beats.delete(); got_seg.delete(); exp_seg.delete();
    check("t6_rst_valids", {78'b0, axis_out_tvalid, seg_out_tvalid}, 80'd0);
    for (int k = 0; k < 64; k++) pkt[k] = 8'(k + 8'h70);
    send_pkt(64, 1'b0, 1'b0);
    drain();
    check("t6_seg", {47'b0, got_seg[0]}, {47'b0, 1'b1, 32'h7F7E_7D7C});
    compare("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
